// File: rtl/activate.sv
// Activation stage: forward sigmoid (PLAN) or saturating ReLU on a Q8.8 input,
// backward scaling of the downstream error by the stored derivative.
module activate #(
  parameter int FUNC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        arg_stb,
  input  logic [15:0] arg_dat,
  output logic        arg_rdy,
  output logic        res_stb,
  output logic [7:0]  res_dat,
  input  logic        res_rdy,
  input  logic        err_stb,
  input  logic [15:0] err_dat,
  output logic        err_rdy,
  output logic        fbk_stb,
  output logic [15:0] fbk_dat,
  input  logic        fbk_rdy
);

  typedef enum logic [2:0] {ARG, FWD, RES, DEL, BWD, FBK} state_t;

  state_t state, state_next;

  logic signed [15:0] x_p0;
  logic signed [15:0] e_p0;
  logic [8:0]         act_p1;
  logic [8:0]         d_p1;
  logic [8:0]         act_fwd;
  logic [8:0]         d_fwd;
  logic signed [25:0] prod_p1;

  function automatic logic [8:0] sig_act(input logic signed [15:0] x);
    logic [16:0] a;
    logic [8:0]  yp;
    // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping
    a = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
    if (a >= 17'd1280)     yp = 9'd256;
    else if (a >= 17'd608) yp = 9'(a >> 5) + 9'd216;
    else if (a >= 17'd256) yp = 9'(a >> 3) + 9'd160;
    else                   yp = 9'(a >> 2) + 9'd128;
    return x[15] ? (9'd256 - yp) : yp;
  endfunction

  function automatic logic [8:0] sig_deriv(input logic [8:0] y9);
    logic [16:0] p;
    p = 17'(y9) * 17'(9'd256 - y9);
    return 9'(p >> 8);
  endfunction

  function automatic logic [8:0] relu_act(input logic signed [15:0] x);
    if (x <= 16'sd0)        return 9'd0;
    else if (x >= 16'sd255) return 9'd255;
    else                    return {1'b0, x[7:0]};
  endfunction

  function automatic logic [8:0] relu_deriv(input logic signed [15:0] x);
    return (x > 16'sd0 && x < 16'sd255) ? 9'd256 : 9'd0;
  endfunction

  always_comb begin
    act_fwd = 9'd0;
    d_fwd   = 9'd0;
    if (FUNC == 0) begin
      act_fwd = sig_act(x_p0);
      d_fwd   = sig_deriv(act_fwd);
    end else begin
      act_fwd = relu_act(x_p0);
      d_fwd   = relu_deriv(x_p0);
    end
  end

  // d <= 256 keeps |e*d>>8| <= |e|, so bits [23:8] never overflow
  assign prod_p1 = e_p0 * $signed({1'b0, d_p1});
  assign res_dat = act_p1[8] ? 8'hFF : act_p1[7:0];
  assign arg_rdy = (state == ARG);
  assign err_rdy = (state == DEL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARG;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARG:     if (arg_stb) state_next = FWD;
      FWD:     state_next = RES;
      RES:     if (res_rdy) state_next = en ? DEL : ARG;
      DEL:     if (err_stb) state_next = BWD;
      BWD:     state_next = FBK;
      FBK:     if (fbk_rdy) state_next = ARG;
      default: state_next = ARG;
    endcase
  end

  // stage p0: operand capture; stage p1: activation/derivative and delta
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_p0    <= '0;
      e_p0    <= '0;
      act_p1  <= '0;
      d_p1    <= '0;
      res_stb <= 1'b0;
      fbk_stb <= 1'b0;
      fbk_dat <= '0;
    end else begin
      if (state == ARG && arg_stb) x_p0 <= arg_dat;
      if (state == FWD) begin
        act_p1  <= act_fwd;
        d_p1    <= d_fwd;
        res_stb <= 1'b1;
      end
      if (state == RES && res_rdy) res_stb <= 1'b0;
      if (state == DEL && err_stb) e_p0 <= err_dat;
      if (state == BWD) begin
        fbk_dat <= 16'(prod_p1 >>> 8);
        fbk_stb <= 1'b1;
      end
      if (state == FBK && fbk_rdy) fbk_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_activate.sv
// Bench for activate: sigmoid and ReLU instances share stimulus and are checked
// against an integer reference model of the activation rules.
module tb_activate;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        arg_stb;
  logic [15:0] arg_dat;
  logic        res_rdy;
  logic        err_stb;
  logic [15:0] err_dat;
  logic        fbk_rdy;

  logic        arg_rdy0, res_stb0, err_rdy0, fbk_stb0;
  logic [7:0]  res_dat0;
  logic [15:0] fbk_dat0;
  logic        arg_rdy1, res_stb1, err_rdy1, fbk_stb1;
  logic [7:0]  res_dat1;
  logic [15:0] fbk_dat1;

  int n_cmp = 0;
  int n_err = 0;
  int last_x = 0;

  always #5 clk = ~clk;

  activate #(.FUNC(0)) dut0 (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy0),
    .res_stb(res_stb0), .res_dat(res_dat0), .res_rdy(res_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy0),
    .fbk_stb(fbk_stb0), .fbk_dat(fbk_dat0), .fbk_rdy(fbk_rdy)
  );

  activate #(.FUNC(1)) dut1 (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy1),
    .res_stb(res_stb1), .res_dat(res_dat1), .res_rdy(res_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy1),
    .fbk_stb(fbk_stb1), .fbk_dat(fbk_dat1), .fbk_rdy(fbk_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer evaluation of the activation rules
  function automatic int sig_y9(int x);
    int a, yp;
    a = (x < 0) ? -x : x;
    if (a >= 1280)     yp = 256;
    else if (a >= 608) yp = a / 32 + 216;
    else if (a >= 256) yp = a / 8 + 160;
    else               yp = a / 4 + 128;
    return (x < 0) ? 256 - yp : yp;
  endfunction

  function automatic int m_out(int func, int x);
    int y;
    if (func == 0) begin
      y = sig_y9(x);
      return (y == 256) ? 255 : y;
    end
    if (x <= 0) return 0;
    if (x >= 255) return 255;
    return x;
  endfunction

  function automatic int m_deriv(int func, int x);
    int y;
    if (func == 0) begin
      y = sig_y9(x);
      return (y * (256 - y)) / 256;
    end
    return (x > 0 && x < 255) ? 256 : 0;
  endfunction

  function automatic logic [31:0] m_fbk(int func, int x, int e);
    int p;
    p = (e * m_deriv(func, x)) >>> 8;
    return {16'h0, 16'(p)};
  endfunction

  task automatic fwd(input logic [15:0] x, input logic en_v, input int bp);
    int xi;
    logic [31:0] e0, e1;
    xi = int'($signed(x));
    last_x = xi;
    e0 = m_out(0, xi);
    e1 = m_out(1, xi);
    chk("arg_rdy_idle", {30'h0, arg_rdy0, arg_rdy1}, 32'h3);
    arg_dat = x; arg_stb = 1'b1;
    @(posedge clk); #1;
    arg_stb = 1'b0; arg_dat = 16'($urandom);
    chk("res_stb_early", {30'h0, res_stb0, res_stb1}, 32'h0);
    @(posedge clk); #1;
    chk("res_stb_rise", {30'h0, res_stb0, res_stb1}, 32'h3);
    chk("res_dat_sig", {24'h0, res_dat0}, e0);
    chk("res_dat_relu", {24'h0, res_dat1}, e1);
    en = en_v;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_res_stb", {30'h0, res_stb0, res_stb1}, 32'h3);
      chk("bp_res_dat", {16'h0, res_dat0, res_dat1}, {16'h0, e0[7:0], e1[7:0]});
      chk("bp_rdys", {28'h0, arg_rdy0, arg_rdy1, err_rdy0, err_rdy1}, 32'h0);
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    en = 1'($urandom);
    chk("res_stb_fall", {30'h0, res_stb0, res_stb1}, 32'h0);
    chk("post_res_arg_rdy", {30'h0, arg_rdy0, arg_rdy1}, en_v ? 32'h0 : 32'h3);
    chk("post_res_err_rdy", {30'h0, err_rdy0, err_rdy1}, en_v ? 32'h3 : 32'h0);
  endtask

  task automatic bwd(input logic [15:0] e, input int bp);
    int ei;
    logic [31:0] f0, f1;
    ei = int'($signed(e));
    f0 = m_fbk(0, last_x, ei);
    f1 = m_fbk(1, last_x, ei);
    chk("err_rdy_del", {30'h0, err_rdy0, err_rdy1}, 32'h3);
    err_dat = e; err_stb = 1'b1;
    @(posedge clk); #1;
    err_stb = 1'b0; err_dat = 16'($urandom);
    chk("fbk_stb_early", {30'h0, fbk_stb0, fbk_stb1}, 32'h0);
    @(posedge clk); #1;
    chk("fbk_stb_rise", {30'h0, fbk_stb0, fbk_stb1}, 32'h3);
    chk("fbk_dat_sig", {16'h0, fbk_dat0}, f0);
    chk("fbk_dat_relu", {16'h0, fbk_dat1}, f1);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_fbk_stb", {30'h0, fbk_stb0, fbk_stb1}, 32'h3);
      chk("bp_fbk_dat", {fbk_dat0, fbk_dat1}, {f0[15:0], f1[15:0]});
      chk("bp_fbk_rdys", {28'h0, arg_rdy0, arg_rdy1, err_rdy0, err_rdy1}, 32'h0);
    end
    fbk_rdy = 1'b1;
    @(posedge clk); #1;
    fbk_rdy = 1'b0;
    chk("fbk_stb_fall", {30'h0, fbk_stb0, fbk_stb1}, 32'h0);
    chk("post_fbk_arg_rdy", {30'h0, arg_rdy0, arg_rdy1}, 32'h3);
  endtask

  logic [15:0] sig_x [7] = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0500, 16'hFF00, 16'h8000};
  logic [7:0]  sig_y [7] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hFF, 8'h40, 8'h00};
  logic [15:0] edge_x [8] = '{16'h00FF, 16'h00FE, 16'h0001, 16'h04FF, 16'h0260, 16'h025F, 16'hFB00, 16'h7FFF};

  initial begin
    rst = 1'b0; en = 1'b0; arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b0;
    err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b0;
    #22;
    chk("rst_strobes", {28'h0, res_stb0, res_stb1, fbk_stb0, fbk_stb1}, 32'h0);
    chk("rst_data", {res_dat0, fbk_dat0[7:0], res_dat1, fbk_dat1[7:0]}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_arg_rdy", {30'h0, arg_rdy0, arg_rdy1}, 32'h3);

    // Directed sigmoid table, forward only, back-to-back
    for (int i = 0; i < 7; i++) begin
      fwd(sig_x[i], 1'b0, 0);
      chk("sig_table", {24'h0, res_dat0}, {24'h0, sig_y[i]});
    end

    // Sigmoid backward at x=0 (d=64)
    fwd(16'h0000, 1'b1, 0);
    bwd(16'h0100, 0);
    chk("sig_bwd_pos", {16'h0, fbk_dat0}, 32'h0040);
    fwd(16'h0000, 1'b1, 0);
    bwd(16'hFF00, 0);
    chk("sig_bwd_neg", {16'h0, fbk_dat0}, 32'hFFC0);

    // ReLU directed
    fwd(16'h0040, 1'b1, 0);
    chk("relu_mid_res", {24'h0, res_dat1}, 32'h40);
    bwd(16'h1234, 0);
    chk("relu_mid_fbk", {16'h0, fbk_dat1}, 32'h1234);
    fwd(16'hFFF0, 1'b1, 0);
    chk("relu_neg_res", {24'h0, res_dat1}, 32'h00);
    bwd(16'h1234, 0);
    chk("relu_neg_fbk", {16'h0, fbk_dat1}, 32'h0000);
    fwd(16'h0200, 1'b1, 0);
    chk("relu_sat_res", {24'h0, res_dat1}, 32'hFF);
    bwd(16'h1234, 0);
    chk("relu_sat_fbk", {16'h0, fbk_dat1}, 32'h0000);

    // Backpressure on both return channels
    fwd(16'h0180, 1'b1, 5);
    bwd(16'h8000, 5);

    // err_stb while in ARG is ignored
    err_dat = 16'h7777; err_stb = 1'b1;
    @(posedge clk); #1;
    err_stb = 1'b0;
    chk("err_in_arg_rdy", {30'h0, arg_rdy0, arg_rdy1}, 32'h3);
    chk("err_in_arg_fbk", {30'h0, fbk_stb0, fbk_stb1}, 32'h0);

    // arg_stb while in DEL is ignored
    fwd(16'h0050, 1'b1, 1);
    arg_dat = 16'h0300; arg_stb = 1'b1;
    @(posedge clk); #1;
    arg_stb = 1'b0;
    chk("arg_in_del_state", {28'h0, arg_rdy0, arg_rdy1, err_rdy0, err_rdy1}, 32'h3);
    chk("arg_in_del_res", {30'h0, res_stb0, res_stb1}, 32'h0);
    bwd(16'h0A00, 0);

    // Boundary and random traffic
    for (int i = 0; i < 8; i++) begin
      fwd(edge_x[i], 1'b1, 0);
      bwd(16'($urandom), 0);
    end
    for (int i = 0; i < 40; i++) begin
      logic       en_v;
      en_v = 1'($urandom);
      fwd(16'($urandom), en_v, $urandom_range(0, 3));
      if (en_v) bwd(16'($urandom), $urandom_range(0, 3));
    end

    // Asynchronous reset while stalled in FBK
    fwd(16'h0020, 1'b1, 0);
    err_dat = 16'h0400; err_stb = 1'b1;
    @(posedge clk); #1;
    err_stb = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_fbk_stb", {30'h0, fbk_stb0, fbk_stb1}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_fbk_stb", {30'h0, fbk_stb0, fbk_stb1}, 32'h0);
    chk("async_rst_res_stb", {30'h0, res_stb0, res_stb1}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arg_rdy", {30'h0, arg_rdy0, arg_rdy1}, 32'h3);
    chk("post_rst_data", {res_dat0, res_dat1, 16'h0}, 32'h0);
    chk("post_rst_fbk", {fbk_dat0, fbk_dat1}, 32'h0);
    chk("post_rst_stb", {28'h0, res_stb0, res_stb1, fbk_stb0, fbk_stb1}, 32'h0);
    fwd(16'h0100, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
